rr_arb_2x1_nbit: RTL

//  Two-requester round-robin arbiter with a registered N-bit output stage.
//  - Picks one of two valid/ready sources (w0, w1) per accepted transfer.
//  - Drives the select into a 2:1 N-bit select stage and registers the result for one downstream consumer.
//  - Sits directly upstream of the consumer; it is the stage that generates and holds the mux select.

---
 rtl/rr_arb_2x1_nbit_pkg.sv | 12 +
 rtl/mux_2x1_nbit.sv | 13 +
 rtl/rr_arb_2x1_nbit.sv | 101 ++++++++++
 3 files changed

// File: rtl/rr_arb_2x1_nbit_pkg.sv
// rtl/rr_arb_2x1_nbit_pkg.sv - shared state and select encodings for the round-robin arbiter
package rr_arb_2x1_nbit_pkg;

  // Output register occupancy
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Mux select / grant encoding
  localparam logic SEL_W0 = 1'b0;
  localparam logic SEL_W1 = 1'b1;

endpackage

// File: rtl/mux_2x1_nbit.sv
// rtl/mux_2x1_nbit.sv - combinational 2:1 N-bit select
module mux_2x1_nbit #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic         i_sel,
  output logic [N-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/rr_arb_2x1_nbit.sv
// rtl/rr_arb_2x1_nbit.sv - two-source round-robin arbiter with registered N-bit output
module rr_arb_2x1_nbit
  import rr_arb_2x1_nbit_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  w0,
  input  logic          v0,
  output logic          rdy0,
  input  logic [N-1:0]  w1,
  input  logic          v1,
  output logic          rdy1,
  output logic [N-1:0]  f,
  output logic          f_valid,
  input  logic          f_ready,
  output logic          s,
  output logic [CW-1:0] gcnt0,
  output logic [CW-1:0] gcnt1
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          r_state;
  logic          r_last;
  logic          r_s;
  logic [N-1:0]  r_f;
  logic [CW-1:0] r_gcnt0;
  logic [CW-1:0] r_gcnt1;

  logic          w_accept;
  logic          w_any;
  logic          w_gnt;
  logic          w_xfer;
  logic [N-1:0]  w_mux;

  // The register can take a word when it is empty or being drained this cycle
  assign w_accept = (r_state == ST_EMPTY) | f_ready;
  assign w_any    = v0 | v1;
  assign w_xfer   = w_accept & w_any;

  // Grant: a lone requester wins outright, contention goes to the source not served last
  always_comb begin
    w_gnt = SEL_W0;
    if (v0 && v1) begin
      w_gnt = ~r_last;
    end else if (v1) begin
      w_gnt = SEL_W1;
    end
  end

  // Ready is gated with rst_n so no source sees a handshake while the state is being forced
  assign rdy0 = rst_n & w_accept & v0 & (w_gnt == SEL_W0);
  assign rdy1 = rst_n & w_accept & v1 & (w_gnt == SEL_W1);

  mux_2x1_nbit #(
    .N (N)
  ) u_mux (
    .i_d0  (w0),
    .i_d1  (w1),
    .i_sel (w_gnt),
    .o_y   (w_mux)
  );

  // Output register FSM: loads on a transfer, holds data/select otherwise, tracks fairness and grant counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_f     <= '0;
      r_s     <= SEL_W0;
      r_last  <= SEL_W1;
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else begin
      if (w_xfer) begin
        r_f    <= w_mux;
        r_s    <= w_gnt;
        r_last <= w_gnt;
        if (w_gnt == SEL_W0) begin
          if (r_gcnt0 != CNT_MAX) r_gcnt0 <= r_gcnt0 + CNT_ONE;
        end else begin
          if (r_gcnt1 != CNT_MAX) r_gcnt1 <= r_gcnt1 + CNT_ONE;
        end
      end
      case (r_state)
        ST_EMPTY: if (w_xfer) r_state <= ST_FULL;
        ST_FULL:  if (f_ready && !w_any) r_state <= ST_EMPTY;
      endcase
    end
  end

  assign f       = r_f;
  assign s       = r_s;
  assign f_valid = (r_state == ST_FULL);
  assign gcnt0   = r_gcnt0;
  assign gcnt1   = r_gcnt1;

endmodule
